ra_64x72_2r1w_ctl: RTL

Request-side controller directly upstream of the 64x72 2R1W register-file array wrapper (LATCHRD=1). It accepts two read requests and one write request per cycle over valid/ready handshakes and drives the array's enables, addresses, write data and strobe. It returns read data with a fixed 2-cycle latency and a response-valid flag, and forwards same-cycle write data to colliding reads. After reset it sequences a 64-entry array initialisation before accepting traffic.

---
 rtl/ra_64x72_2r1w_ctl_pkg.sv | 31 +++
 rtl/ra_64x72_2r1w_ctl_rd_pipe.sv | 59 +++++
 rtl/ra_64x72_2r1w_ctl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ra_64x72_2r1w_ctl_pkg.sv
// Shared sizes, FSM encoding and byte-parity helpers for the 64x72 2R1W array controller.
// Parity helpers are used only when RA_PARITY_EN is defined.
package ra_64x72_2r1w_ctl_pkg;

  localparam int ADR_W  = 6;
  localparam int DAT_W  = 72;
  localparam int DEPTH  = 64;
  localparam int RD_LAT = 2;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Even parity per byte: bit k is the XOR of payload byte k.
  function automatic logic [7:0] byte_par(input logic [63:0] d);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      p[k] = ^d[8*k +: 8];
    end
    return p;
  endfunction

  function automatic logic [DAT_W-1:0] gen_par_word(input logic [DAT_W-1:0] w);
    return {byte_par(w[63:0]), w[63:0]};
  endfunction

  function automatic logic par_err(input logic [DAT_W-1:0] w);
    return |(w[71:64] ^ byte_par(w[63:0]));
  endfunction

endpackage

// File: rtl/ra_64x72_2r1w_ctl_rd_pipe.sv
// Per-read-port response pipe: 2-stage valid/bypass tracking, data select and parity check.
// Parity check is present only when RA_PARITY_EN is defined.
module ra_ctl_rd_pipe
  import ra_64x72_2r1w_ctl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             acc,
  input  logic             byp,
  input  logic [DAT_W-1:0] byp_dat,
  input  logic [DAT_W-1:0] ra_rd_dat,
  output logic             rsp_vld,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_perr
);

  logic             vld1_r, byp1_r, vld2_r, byp2_r;
  logic [DAT_W-1:0] dat1_r, dat2_r;

  // Carry request valid and any forwarded write word alongside the array access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld1_r <= 1'b0;
      byp1_r <= 1'b0;
      dat1_r <= {DAT_W{1'b0}};
      vld2_r <= 1'b0;
      byp2_r <= 1'b0;
      dat2_r <= {DAT_W{1'b0}};
    end else begin
      vld1_r <= acc;
      byp1_r <= acc & byp;
      dat1_r <= (acc & byp) ? byp_dat : {DAT_W{1'b0}};
      vld2_r <= vld1_r;
      byp2_r <= byp1_r;
      dat2_r <= dat1_r;
    end
  end

  // Array read data lands in the response cycle itself, so the select is combinational.
  always_comb begin
    rsp_dat = {DAT_W{1'b0}};
    if (!vld2_r) begin
      rsp_dat = {DAT_W{1'b0}};
    end else if (byp2_r) begin
      rsp_dat = dat2_r;
    end else begin
      rsp_dat = ra_rd_dat;
    end
  end

  assign rsp_vld = vld2_r;

`ifdef RA_PARITY_EN
  assign rsp_perr = vld2_r & par_err(rsp_dat);
`else
  assign rsp_perr = 1'b0;
`endif

endmodule

// File: rtl/ra_64x72_2r1w_ctl.sv
// Request-side controller for the 64x72 2R1W register-file array: init sequencing,
// request acceptance, strobe generation and same-cycle write->read forwarding. Option: RA_PARITY_EN.
module ra_64x72_2r1w_ctl
  import ra_64x72_2r1w_ctl_pkg::*;
#(
  parameter logic [DAT_W-1:0] INIT_VAL = 72'h0,
  parameter bit               INIT_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_req_vld_0,
  input  logic [ADR_W-1:0] rd_req_adr_0,
  output logic             rd_req_rdy_0,
  output logic             rd_rsp_vld_0,
  output logic [DAT_W-1:0] rd_rsp_dat_0,
  output logic             rd_rsp_perr_0,
  input  logic             rd_req_vld_1,
  input  logic [ADR_W-1:0] rd_req_adr_1,
  output logic             rd_req_rdy_1,
  output logic             rd_rsp_vld_1,
  output logic [DAT_W-1:0] rd_rsp_dat_1,
  output logic             rd_rsp_perr_1,
  input  logic             wr_req_vld_0,
  input  logic [ADR_W-1:0] wr_req_adr_0,
  input  logic [DAT_W-1:0] wr_req_dat_0,
  output logic             wr_req_rdy_0,
  output logic             init_done,
  output logic             ra_strobe,
  output logic             ra_rd_enb_0,
  output logic [ADR_W-1:0] ra_rd_adr_0,
  input  logic [DAT_W-1:0] ra_rd_dat_0,
  output logic             ra_rd_enb_1,
  output logic [ADR_W-1:0] ra_rd_adr_1,
  input  logic [DAT_W-1:0] ra_rd_dat_1,
  output logic             ra_wr_enb_0,
  output logic [ADR_W-1:0] ra_wr_adr_0,
  output logic [DAT_W-1:0] ra_wr_dat_0
);

  localparam logic [0:0] ST_RESET = INIT_EN ? ST_INIT : ST_RUN;

  logic [0:0]       state_r, state_nxt_s;
  logic [ADR_W-1:0] init_adr_r;
  logic             run_r, strobe_r;
  logic             init_wr_s, rd_acc_0_s, rd_acc_1_s, wr_acc_s, byp_0_s, byp_1_s;
  logic [DAT_W-1:0] wr_word_s, init_word_s;

`ifdef RA_PARITY_EN
  assign wr_word_s   = gen_par_word(wr_req_dat_0);
  assign init_word_s = gen_par_word(INIT_VAL);
`else
  assign wr_word_s   = wr_req_dat_0;
  assign init_word_s = INIT_VAL;
`endif

  // The array must see no writes while reset is held, even though the FSM sits in INIT.
  assign init_wr_s  = (state_r == ST_INIT) && reset;
  assign rd_acc_0_s = rd_req_vld_0 & run_r;
  assign rd_acc_1_s = rd_req_vld_1 & run_r;
  assign wr_acc_s   = wr_req_vld_0 & run_r;
  assign byp_0_s    = rd_acc_0_s & wr_acc_s & (rd_req_adr_0 == wr_req_adr_0);
  assign byp_1_s    = rd_acc_1_s & wr_acc_s & (rd_req_adr_1 == wr_req_adr_0);

  // INIT walks all entries once, then RUN is permanent until reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_adr_r == 6'd63) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_RESET;
    endcase
  end

  // FSM, init address counter, ready/done flag and array strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RESET;
      init_adr_r <= {ADR_W{1'b0}};
      run_r      <= 1'b0;
      strobe_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      init_adr_r <= (state_r == ST_INIT) ? init_adr_r + 6'd1 : {ADR_W{1'b0}};
      run_r      <= (state_nxt_s == ST_RUN);
      strobe_r   <= ra_rd_enb_0 | ra_rd_enb_1 | ra_wr_enb_0;
    end
  end

  assign rd_req_rdy_0 = run_r;
  assign rd_req_rdy_1 = run_r;
  assign wr_req_rdy_0 = run_r;
  assign init_done    = run_r;
  assign ra_strobe    = strobe_r;

  assign ra_rd_enb_0 = rd_acc_0_s;
  assign ra_rd_adr_0 = rd_acc_0_s ? rd_req_adr_0 : {ADR_W{1'b0}};
  assign ra_rd_enb_1 = rd_acc_1_s;
  assign ra_rd_adr_1 = rd_acc_1_s ? rd_req_adr_1 : {ADR_W{1'b0}};

  // Write port is owned by the init sequencer until RUN.
  always_comb begin
    ra_wr_enb_0 = 1'b0;
    ra_wr_adr_0 = {ADR_W{1'b0}};
    ra_wr_dat_0 = {DAT_W{1'b0}};
    if (init_wr_s) begin
      ra_wr_enb_0 = 1'b1;
      ra_wr_adr_0 = init_adr_r;
      ra_wr_dat_0 = init_word_s;
    end else if (wr_acc_s) begin
      ra_wr_enb_0 = 1'b1;
      ra_wr_adr_0 = wr_req_adr_0;
      ra_wr_dat_0 = wr_word_s;
    end else begin
      ra_wr_enb_0 = 1'b0;
      ra_wr_adr_0 = {ADR_W{1'b0}};
      ra_wr_dat_0 = {DAT_W{1'b0}};
    end
  end

  ra_ctl_rd_pipe u_rd_pipe_0 (
    .clk       (clk),
    .reset     (reset),
    .acc       (rd_acc_0_s),
    .byp       (byp_0_s),
    .byp_dat   (ra_wr_dat_0),
    .ra_rd_dat (ra_rd_dat_0),
    .rsp_vld   (rd_rsp_vld_0),
    .rsp_dat   (rd_rsp_dat_0),
    .rsp_perr  (rd_rsp_perr_0)
  );

  ra_ctl_rd_pipe u_rd_pipe_1 (
    .clk       (clk),
    .reset     (reset),
    .acc       (rd_acc_1_s),
    .byp       (byp_1_s),
    .byp_dat   (ra_wr_dat_0),
    .ra_rd_dat (ra_rd_dat_1),
    .rsp_vld   (rd_rsp_vld_1),
    .rsp_dat   (rd_rsp_dat_1),
    .rsp_perr  (rd_rsp_perr_1)
  );

endmodule
